uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART transmitter behind a valid/ready input handshake.
// Optional macro UART_TX_BUFFER_EN adds a one-word holding register for gapless frames.
module uart_tx #(
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_BIT = 0,
    parameter int DATA_LEN   = 8,
    parameter int STOP_BIT   = 1,
    parameter int CLK_FREQ   = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_LEN-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                tx,
    output logic                tx_busy,
    output logic                tx_done
);

    localparam int HALF_RAW = CLK_FREQ / (2 * BAUD_RATE);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int HCW      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int STOP_HB  = (STOP_BIT == 2) ? 4 : (STOP_BIT == 3) ? 3 : 2;
    localparam bit HAS_PAR  = (PARITY_BIT == 1) || (PARITY_BIT == 2);

    localparam logic [HCW-1:0] HCNT_MAX  = HCW'(HALF - 1);
    localparam logic [3:0]     LAST_BIT  = 4'(DATA_LEN - 1);
    localparam logic [1:0]     LAST_STOP = 2'(STOP_HB - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [HCW-1:0]      hcnt, hcnt_n;
    logic [1:0]          hb, hb_n;
    logic [3:0]          bcnt, bcnt_n;
    logic [DATA_LEN-1:0] shreg, shreg_n;
    logic                par, par_n;
    logic                load, load_n;
    logic                done_q, done_n;
    logic                tx_q, tx_n;
    logic                accept;
    logic                bypass;
    logic                tick;

`ifdef UART_TX_BUFFER_EN
    logic [DATA_LEN-1:0] hold_q, hold_n;
    logic                hold_full, hold_full_n;
`endif

    function automatic logic par_of(input logic [DATA_LEN-1:0] d);
        return (PARITY_BIT == 1) ? ~^d : ^d;
    endfunction

`ifdef UART_TX_BUFFER_EN
    assign tx_ready = !hold_full;
`else
    assign tx_ready = (state == S_IDLE) && !load;
`endif

    // Idle with no word staged: an accepted word goes straight to the shifter.
    assign bypass = (state == S_IDLE) && !load;
    assign accept = tx_valid && tx_ready;
    assign tick   = (hcnt == HCNT_MAX);

    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        hb_n    = hb;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        par_n   = par;
        load_n  = load;
        done_n  = 1'b0;
`ifdef UART_TX_BUFFER_EN
        hold_n      = hold_q;
        hold_full_n = hold_full;
        if (accept && !bypass) begin
            hold_n      = tx_data;
            hold_full_n = 1'b1;
        end
`endif
        if (state != S_IDLE) begin
            hcnt_n = tick ? '0 : hcnt + HCW'(1);
            if (tick) begin
                hb_n = hb + 2'd1;
            end
        end

        case (state)
            S_IDLE: begin
                hcnt_n = '0;
                hb_n   = '0;
                bcnt_n = '0;
                if (load) begin
                    state_n = S_START;
                    load_n  = 1'b0;
                end else if (accept) begin
                    shreg_n = tx_data;
                    par_n   = par_of(tx_data);
                    load_n  = 1'b1;
                end
`ifdef UART_TX_BUFFER_EN
                else if (hold_full) begin
                    shreg_n     = hold_q;
                    par_n       = par_of(hold_q);
                    load_n      = 1'b1;
                    hold_full_n = 1'b0;
                end
`endif
            end
            S_START: begin
                if (tick && hb == 2'd1) begin
                    state_n = S_DATA;
                    hb_n    = '0;
                end
            end
            S_DATA: begin
                if (tick && hb == 2'd1) begin
                    hb_n    = '0;
                    shreg_n = shreg >> 1;
                    if (bcnt == LAST_BIT) begin
                        bcnt_n  = '0;
                        state_n = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_n = bcnt + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick && hb == 2'd1) begin
                    state_n = S_STOP;
                    hb_n    = '0;
                end
            end
            S_STOP: begin
                if (tick && hb == LAST_STOP) begin
                    hb_n   = '0;
                    done_n = 1'b1;
`ifdef UART_TX_BUFFER_EN
                    // Chain the held word so its start bit follows with no gap.
                    if (hold_full) begin
                        state_n     = S_START;
                        shreg_n     = hold_q;
                        par_n       = par_of(hold_q);
                        hold_full_n = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                    end
`else
                    state_n = S_IDLE;
`endif
                end
            end
            default: begin
                state_n = S_IDLE;
                hcnt_n  = '0;
                hb_n    = '0;
                bcnt_n  = '0;
                load_n  = 1'b0;
            end
        endcase
    end

    // Line level is decoded from the next state so tx leaves a flop.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = par_n;
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            hcnt   <= '0;
            hb     <= '0;
            bcnt   <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            load   <= 1'b0;
            done_q <= 1'b0;
            tx_q   <= 1'b1;
        end else begin
            state  <= state_n;
            hcnt   <= hcnt_n;
            hb     <= hb_n;
            bcnt   <= bcnt_n;
            shreg  <= shreg_n;
            par    <= par_n;
            load   <= load_n;
            done_q <= done_n;
            tx_q   <= tx_n;
        end
    end

`ifdef UART_TX_BUFFER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else begin
            hold_q    <= hold_n;
            hold_full <= hold_full_n;
        end
    end
`endif

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign tx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench over several uart_tx configurations.
// Expected line waveforms are built from frame rules, not from the RTL structure.
module tb_uart_tx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int HALF   = CLK_HZ / (2 * BAUD);
    localparam int NI     = 5;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input int inst, input string name,
                       input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s [cfg %0d]: actual %0h, required %0h",
                     name, inst, act, req);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gen_cfg
        localparam int P = (g == 1 || g == 4) ? 1 : (g == 2 || g == 3) ? 2 : 0;
        localparam int D = (g == 3) ? 5 : (g == 4) ? 9 : 8;
        localparam int S = (g == 1 || g == 3) ? 3 : (g == 2 || g == 4) ? 2 : 1;
        localparam int SH = (S == 2) ? 4 : (S == 3) ? 3 : 2;
        localparam int NB = 1 + D + ((P != 0) ? 1 : 0);
        localparam int FLEN = HALF * (2 * NB + SH);
        localparam logic [8:0] MASK = 9'((1 << D) - 1);

        logic         rst;
        logic [D-1:0] tx_data;
        logic         tx_valid;
        logic         tx_ready;
        logic         tx;
        logic         tx_busy;
        logic         tx_done;

        logic [8:0]   exp_q[$];
        logic [255:0] obs;
        logic [255:0] expw;
        int           cyc = 0;
        bit           inframe = 1'b0;
        bit           bad_busy = 1'b0;
        bit           bad_done = 1'b0;
        bit           fin = 1'b0;

        uart_tx #(
            .BAUD_RATE (BAUD),
            .PARITY_BIT(P),
            .DATA_LEN  (D),
            .STOP_BIT  (S),
            .CLK_FREQ  (CLK_HZ)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .tx_data (tx_data),
            .tx_valid(tx_valid),
            .tx_ready(tx_ready),
            .tx      (tx),
            .tx_busy (tx_busy),
            .tx_done (tx_done)
        );

        // Line level per clock for one frame; stop region stays high.
        function automatic logic [255:0] model(input logic [8:0] w);
            logic [255:0] v;
            int c;
            int ones;
            logic lv;
            v = '1;
            c = 0;
            ones = 0;
            for (int i = 0; i < D; i++) ones += int'(w[i]);
            for (int b = 0; b < NB; b++) begin
                if (b == 0) lv = 1'b0;
                else if (b <= D) lv = w[b-1];
                else if (P == 1) lv = (ones % 2 == 0);
                else lv = (ones % 2 == 1);
                for (int k = 0; k < 2 * HALF; k++) begin
                    v[c] = lv;
                    c++;
                end
            end
            return v;
        endfunction

        always @(negedge clk) begin
            if (!rst) begin
                inframe = 1'b0;
            end else begin
                if (inframe) begin
                    if (cyc < FLEN) begin
                        obs[cyc] = tx;
                        if (!tx_busy) bad_busy = 1'b1;
                        if (tx_done) bad_done = 1'b1;
                        cyc++;
                    end else begin
                        chk(g, "done_at_end", tx_done, 1'b1);
                        chk(g, "early_done", bad_done, 1'b0);
                        chk(g, "busy_in_frame", bad_busy, 1'b0);
                        chk(g, "frame_wave", obs, expw);
                        inframe = 1'b0;
                    end
                end else begin
                    chk(g, "stray_done", tx_done, 1'b0);
                end
                if (!inframe && tx == 1'b0) begin
                    chk(g, "frame_expected", exp_q.size() != 0, 1'b1);
                    expw = (exp_q.size() != 0) ? model(exp_q.pop_front()) : '0;
                    obs = '1;
                    obs[0] = 1'b0;
                    cyc = 1;
                    bad_busy = !tx_busy;
                    bad_done = tx_done;
                    inframe = 1'b1;
                end
            end
        end

        task automatic send(input logic [8:0] w, input bit lat);
            int n;
            n = 0;
            @(negedge clk);
            tx_data = w[D-1:0];
            tx_valid = 1'b1;
            while (!tx_ready && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk(g, "ready_wait", tx_ready, 1'b1);
            if (tx_ready) begin
                exp_q.push_back(w & MASK);
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
                tx_data = D'($urandom);
                if (lat) begin
                    chk(g, "lat_tx_k", tx, 1'b1);
                    chk(g, "lat_busy_k", tx_busy, 1'b0);
                    @(posedge clk);
                    #1;
                    chk(g, "lat_tx_k1", tx, 1'b0);
                    chk(g, "lat_busy_k1", tx_busy, 1'b1);
                end
            end else begin
                tx_valid = 1'b0;
            end
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            while ((exp_q.size() != 0 || inframe || tx_busy) && n < 4000) begin
                @(negedge clk);
                n++;
            end
            chk(g, "drain", n < 4000, 1'b1);
            repeat (2) @(negedge clk);
        endtask

        task automatic wait_fall();
            int n;
            n = 0;
            while (tx !== 1'b0 && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk(g, "start_seen", tx, 1'b0);
        endtask

        initial begin
            int cnt;
            int bad;
            int n;
            rst = 1'b1;
            tx_valid = 1'b0;
            tx_data = '0;
            #2 rst = 1'b0;
            repeat (3) @(negedge clk);
            chk(g, "rst_tx", tx, 1'b1);
            chk(g, "rst_ready", tx_ready, 1'b1);
            chk(g, "rst_busy", tx_busy, 1'b0);
            chk(g, "rst_done", tx_done, 1'b0);
            rst = 1'b1;
            repeat (2) @(negedge clk);

            send(9'h0A5, 1'b1);
            wait_idle();
            send(9'h007, 1'b0);
            wait_idle();
            send(9'h0FF, 1'b0);
            wait_idle();

            for (int i = 0; i < 8; i++) begin
                send(9'($urandom), 1'b0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle();

`ifdef UART_TX_BUFFER_EN
            send(9'h055, 1'b0);
            wait_fall();
            repeat (28) @(negedge clk);
            chk(g, "buf_ready_mid", tx_ready, 1'b1);
            send(9'h00F, 1'b0);
            cnt = 0;
            n = 0;
            do begin
                @(negedge clk);
                if (tx_ready && !tx_done) cnt++;
                n++;
            end while (!tx_done && n < 300);
            chk(g, "b2b_done", tx_done, 1'b1);
            chk(g, "b2b_ready_low", cnt, 0);
            chk(g, "b2b_no_gap", tx, 1'b0);
            chk(g, "b2b_ready_back", tx_ready, 1'b1);
            wait_idle();
`else
            send(9'h055, 1'b0);
            cnt = 0;
            bad = 0;
            repeat (FLEN + 5) begin
                @(negedge clk);
                if (tx_busy) cnt++;
                if (tx_busy && tx_ready) bad++;
            end
            chk(g, "busy_len", cnt, FLEN);
            chk(g, "ready_low_frame", bad, 0);
            send(9'h00F, 1'b0);
            wait_idle();
`endif

            send(9'h0A5, 1'b0);
            wait_fall();
            repeat (44) @(negedge clk);
            rst = 1'b0;
            #1;
            chk(g, "abort_tx", tx, 1'b1);
            chk(g, "abort_busy", tx_busy, 1'b0);
            chk(g, "abort_ready", tx_ready, 1'b1);
            chk(g, "abort_done", tx_done, 1'b0);
            exp_q.delete();
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            send(9'h03C, 1'b1);
            wait_idle();
            fin = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(gen_cfg[0].fin && gen_cfg[1].fin && gen_cfg[2].fin &&
                 gen_cfg[3].fin && gen_cfg[4].fin) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk(-1, "global_budget", n < 60000, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
